// File: rtl/hd_pkg.sv
// Shared definitions for the Hamming-distance balancing encoder.
//   hd_width  : width needed to hold a Hamming count of a WIDTH-bit word
//   mode_e    : per-beat encoding mode (bypass or balance)
//   sat_add   : unsigned saturating add used by the statistics counters
package hd_pkg;

    typedef enum logic {
        BYPASS  = 1'b0,
        BALANCE = 1'b1
    } mode_e;

    function automatic int hd_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Operands and limit are zero-extended by the caller; the result never exceeds max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        if (sum_v > {1'b0, max_val}) begin
            return max_val;
        end else begin
            return sum_v[31:0];
        end
    endfunction

endpackage

// File: rtl/hd_balance_encoder_if.sv
// Stream and status bundle of the Hamming-distance balancing encoder.
//   master : stimulus source / output consumer side
//   slave  : encoder side
// Signals: in_valid/in_ready/in_data input stream, balance_en mode select,
// stat_clr statistics clear, out_valid/out_ready output stream, out_data
// primary rail, out_comp dummy rail, out_hd/out_hd_comp/out_hd_sum per-beat
// transition counts, stat_trans/stat_beats saturating statistics.
interface hd_balance_encoder_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
);
    import hd_pkg::*;

    localparam int HD_W = hd_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             balance_en;
    logic             stat_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_comp;
    logic [HD_W-1:0]  out_hd;
    logic [HD_W-1:0]  out_hd_comp;
    logic [HD_W-1:0]  out_hd_sum;
    logic [ACC_W-1:0] stat_trans;
    logic [ACC_W-1:0] stat_beats;

    modport master (
        output in_valid, in_data, balance_en, stat_clr, out_ready,
        input  in_ready, out_valid, out_data, out_comp, out_hd,
               out_hd_comp, out_hd_sum, stat_trans, stat_beats
    );

    modport slave (
        input  in_valid, in_data, balance_en, stat_clr, out_ready,
        output in_ready, out_valid, out_data, out_comp, out_hd,
               out_hd_comp, out_hd_sum, stat_trans, stat_beats
    );

endinterface

// File: rtl/hd_popcount.sv
// Combinational population count.
//   vec   : input vector, WIDTH bits
//   count : number of set bits in vec, HD_W bits
module hd_popcount #(
    parameter int WIDTH = 8,
    parameter int HD_W  = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [HD_W-1:0]  count
);

    // Ripple sum of the individual bits.
    always_comb begin
        count = {HD_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count = count + HD_W'(vec[i]);
        end
    end

endmodule

// File: rtl/hd_balance_encoder.sv
// Hamming-distance balancing encoder. Every accepted word goes out on the
// primary rail; the dummy rail toggles its k = WIDTH - hd lowest bits so the
// combined transitions per beat equal WIDTH (balance mode), or holds still
// (bypass mode). Outputs are registered behind a valid/ready handshake and
// delivered beats feed saturating transition/beat statistics.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : hd_balance_encoder_if slave modport (streams, mode, statistics)
module hd_balance_encoder
    import hd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hd_balance_encoder_if.slave  bus
);

    localparam int          HD_W    = hd_width(WIDTH);
    localparam logic [31:0] ACC_MAX = 32'((64'd1 << ACC_W) - 64'd1);

    logic [WIDTH-1:0] prev_data_r;
    logic [WIDTH-1:0] prev_comp_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] out_comp_r;
    logic [HD_W-1:0]  out_hd_r;
    logic [HD_W-1:0]  out_hd_comp_r;
    logic [HD_W-1:0]  out_hd_sum_r;
    logic [ACC_W-1:0] stat_trans_r;
    logic [ACC_W-1:0] stat_beats_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             deliver_s;
    mode_e            mode_s;
    logic [WIDTH-1:0] diff_s;
    logic [HD_W-1:0]  hd_s;
    logic [HD_W-1:0]  k_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] new_comp_s;
    logic [HD_W-1:0]  hd_comp_s;
    logic [HD_W-1:0]  hd_sum_s;

    // Ready whenever the output slot is empty or being drained this cycle; held low in reset.
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !out_valid_r || bus.out_ready;
        end
    end

    assign accept_s  = bus.in_valid && in_ready_s;
    assign deliver_s = out_valid_r && bus.out_ready;
    assign mode_s    = mode_e'(bus.balance_en);
    assign diff_s    = bus.in_data ^ prev_data_r;

    hd_popcount #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_popcount (
        .vec   (diff_s),
        .count (hd_s)
    );

    assign k_s = HD_W'(WIDTH) - hd_s;

    // Low mask (1 << k) - 1 built bitwise so k = WIDTH yields all ones without overflow.
    always_comb begin
        mask_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(k_s)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // Next dummy word and its transition count for the incoming beat.
    always_comb begin
        new_comp_s = prev_comp_r;
        hd_comp_s  = {HD_W{1'b0}};
        case (mode_s)
            BALANCE: begin
                new_comp_s = prev_comp_r ^ mask_s;
                hd_comp_s  = k_s;
            end
            BYPASS: begin
                new_comp_s = prev_comp_r;
                hd_comp_s  = {HD_W{1'b0}};
            end
            default: begin
                new_comp_s = prev_comp_r;
                hd_comp_s  = {HD_W{1'b0}};
            end
        endcase
        hd_sum_s = hd_s + hd_comp_s;
    end

    // History follows accepted beats only, so a stalled output never disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data_r <= {WIDTH{1'b0}};
            prev_comp_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            prev_data_r <= bus.in_data;
            prev_comp_r <= new_comp_s;
        end
    end

    // Output stage: loads on accept, empties on a deliver with no replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= {WIDTH{1'b0}};
            out_comp_r    <= {WIDTH{1'b0}};
            out_hd_r      <= {HD_W{1'b0}};
            out_hd_comp_r <= {HD_W{1'b0}};
            out_hd_sum_r  <= {HD_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_data_r    <= bus.in_data;
            out_comp_r    <= new_comp_s;
            out_hd_r      <= hd_s;
            out_hd_comp_r <= hd_comp_s;
            out_hd_sum_r  <= hd_sum_s;
        end else if (deliver_s) begin
            out_valid_r   <= 1'b0;
        end
    end

    // Statistics: a clear coinciding with a deliver restarts from that beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_trans_r <= {ACC_W{1'b0}};
            stat_beats_r <= {ACC_W{1'b0}};
        end else if (deliver_s) begin
            if (bus.stat_clr) begin
                stat_trans_r <= ACC_W'(out_hd_sum_r);
                stat_beats_r <= ACC_W'(1'b1);
            end else begin
                stat_trans_r <= ACC_W'(sat_add(32'(stat_trans_r), 32'(out_hd_sum_r), ACC_MAX));
                stat_beats_r <= ACC_W'(sat_add(32'(stat_beats_r), 32'd1, ACC_MAX));
            end
        end else if (bus.stat_clr) begin
            stat_trans_r <= {ACC_W{1'b0}};
            stat_beats_r <= {ACC_W{1'b0}};
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_comp    = out_comp_r;
    assign bus.out_hd      = out_hd_r;
    assign bus.out_hd_comp = out_hd_comp_r;
    assign bus.out_hd_sum  = out_hd_sum_r;
    assign bus.stat_trans  = stat_trans_r;
    assign bus.stat_beats  = stat_beats_r;

endmodule

// File: tb/tb_hd_balance_encoder.sv
// Self-checking bench for hd_balance_encoder. Two instances (ACC_W = 16 and
// ACC_W = 4) share one stimulus stream; a behavioural model predicts every
// output cycle by cycle, and literal expectations pin known beats.
module tb_hd_balance_encoder;

    logic clk = 1'b0;
    logic rst;

    logic       d_in_valid  = 1'b0;
    logic [7:0] d_in_data   = 8'h00;
    logic       d_bal       = 1'b0;
    logic       d_stat_clr  = 1'b0;
    logic       d_out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_valid = 0, m_data = 0, m_comp = 0, m_hd = 0, m_hdc = 0, m_sum = 0;
    int m_prev_data = 0, m_prev_comp = 0;
    int m_trans16 = 0, m_beats16 = 0, m_trans4 = 0, m_beats4 = 0;

    hd_balance_encoder_if #(.WIDTH(8), .ACC_W(16)) bus16 ();
    hd_balance_encoder_if #(.WIDTH(8), .ACC_W(4))  bus4  ();

    assign bus16.in_valid   = d_in_valid;
    assign bus16.in_data    = d_in_data;
    assign bus16.balance_en = d_bal;
    assign bus16.stat_clr   = d_stat_clr;
    assign bus16.out_ready  = d_out_ready;
    assign bus4.in_valid    = d_in_valid;
    assign bus4.in_data     = d_in_data;
    assign bus4.balance_en  = d_bal;
    assign bus4.stat_clr    = d_stat_clr;
    assign bus4.out_ready   = d_out_ready;

    hd_balance_encoder #(.WIDTH(8), .ACC_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    hd_balance_encoder #(.WIDTH(8), .ACC_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Check a DUT value and the model's value against a hand-computed literal.
    task automatic pin(input string name, input int dut_val, input int model_val, input int lit);
        check(name, dut_val, lit);
        check({name, "_model"}, model_val, lit);
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // Model of one clock edge, written from the behavioural rules.
    task automatic model_clock();
        int hd, k;
        bit acc, dlv;
        if (rst) begin
            m_valid = 0; m_data = 0; m_comp = 0; m_hd = 0; m_hdc = 0; m_sum = 0;
            m_prev_data = 0; m_prev_comp = 0;
            m_trans16 = 0; m_beats16 = 0; m_trans4 = 0; m_beats4 = 0;
        end else begin
            acc = d_in_valid && (m_valid == 0 || d_out_ready);
            dlv = (m_valid != 0) && d_out_ready;
            if (dlv) begin
                if (d_stat_clr) begin
                    m_trans16 = m_sum; m_beats16 = 1; m_trans4 = m_sum; m_beats4 = 1;
                end else begin
                    m_trans16 = sat(m_trans16 + m_sum, 65535);
                    m_beats16 = sat(m_beats16 + 1, 65535);
                    m_trans4  = sat(m_trans4 + m_sum, 15);
                    m_beats4  = sat(m_beats4 + 1, 15);
                end
            end else if (d_stat_clr) begin
                m_trans16 = 0; m_beats16 = 0; m_trans4 = 0; m_beats4 = 0;
            end
            if (acc) begin
                hd = $countones(int'(d_in_data) ^ m_prev_data);
                if (d_bal) begin
                    k = 8 - hd;
                    m_comp = (m_prev_comp ^ ((1 << k) - 1)) & 255;
                    m_hdc = k;
                end else begin
                    m_comp = m_prev_comp;
                    m_hdc = 0;
                end
                m_data = int'(d_in_data);
                m_hd = hd;
                m_sum = hd + m_hdc;
                m_valid = 1;
                m_prev_data = m_data;
                m_prev_comp = m_comp;
            end else if (dlv) begin
                m_valid = 0;
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    task automatic compare_cycle();
        int exp_rdy;
        exp_rdy = (!rst && (m_valid == 0 || d_out_ready)) ? 1 : 0;
        check("in_ready16", int'(bus16.in_ready), exp_rdy);
        check("in_ready4", int'(bus4.in_ready), exp_rdy);
        check("out_valid16", int'(bus16.out_valid), m_valid);
        check("out_valid4", int'(bus4.out_valid), m_valid);
        if (m_valid != 0) begin
            check("out_data", int'(bus16.out_data), m_data);
            check("out_comp", int'(bus16.out_comp), m_comp);
            check("out_hd", int'(bus16.out_hd), m_hd);
            check("out_hd_comp", int'(bus16.out_hd_comp), m_hdc);
            check("out_hd_sum", int'(bus16.out_hd_sum), m_sum);
            check("out_comp4", int'(bus4.out_comp), m_comp);
            check("out_hd_sum4", int'(bus4.out_hd_sum), m_sum);
        end
        check("stat_trans16", int'(bus16.stat_trans), m_trans16);
        check("stat_beats16", int'(bus16.stat_beats), m_beats16);
        check("stat_trans4", int'(bus4.stat_trans), m_trans4);
        check("stat_beats4", int'(bus4.stat_beats), m_beats4);
    endtask

    // Drive one cycle: inputs now, compare at negedge, model at posedge, settle.
    task automatic step(input logic v, input logic [7:0] d, input logic bal,
                        input logic clr, input logic ordy, input logic r);
        d_in_valid = v; d_in_data = d; d_bal = bal; d_stat_clr = clr; d_out_ready = ordy; rst = r;
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_clock();
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pin_all_zero(input string tag);
        pin({tag, "_valid"}, int'(bus16.out_valid), m_valid, 0);
        pin({tag, "_data"}, int'(bus16.out_data), m_data, 0);
        pin({tag, "_comp"}, int'(bus16.out_comp), m_comp, 0);
        pin({tag, "_hd"}, int'(bus16.out_hd), m_hd, 0);
        pin({tag, "_hdc"}, int'(bus16.out_hd_comp), m_hdc, 0);
        pin({tag, "_sum"}, int'(bus16.out_hd_sum), m_sum, 0);
        pin({tag, "_trans"}, int'(bus16.stat_trans), m_trans16, 0);
        pin({tag, "_beats"}, int'(bus16.stat_beats), m_beats16, 0);
    endtask

    initial begin
        rst = 1'b1;

        // Reset state
        do_reset();
        pin_all_zero("rst");

        // Balance mode: 0x00, 0xFF, 0x0F
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("b1_comp", int'(bus16.out_comp), m_comp, 8'hFF);
        pin("b1_hd", int'(bus16.out_hd), m_hd, 0);
        pin("b1_hdc", int'(bus16.out_hd_comp), m_hdc, 8);
        pin("b1_sum", int'(bus16.out_hd_sum), m_sum, 8);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("b2_comp", int'(bus16.out_comp), m_comp, 8'hFF);
        pin("b2_hd", int'(bus16.out_hd), m_hd, 8);
        pin("b2_hdc", int'(bus16.out_hd_comp), m_hdc, 0);
        pin("b2_sum", int'(bus16.out_hd_sum), m_sum, 8);
        step(1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("b3_comp", int'(bus16.out_comp), m_comp, 8'hF0);
        pin("b3_hd", int'(bus16.out_hd), m_hd, 4);
        pin("b3_sum", int'(bus16.out_hd_sum), m_sum, 8);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("s3_trans16", int'(bus16.stat_trans), m_trans16, 24);
        pin("s3_beats16", int'(bus16.stat_beats), m_beats16, 3);
        pin("s3_trans4_sat", int'(bus4.stat_trans), m_trans4, 15);
        pin("s3_beats4", int'(bus4.stat_beats), m_beats4, 3);

        // Clear coinciding with a delivered sum-8 beat
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        pin("clr_trans4", int'(bus4.stat_trans), m_trans4, 8);
        pin("clr_beats4", int'(bus4.stat_beats), m_beats4, 1);
        pin("clr_trans16", int'(bus16.stat_trans), m_trans16, 8);
        // Clear alone
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        pin("clr_only_beats16", int'(bus16.stat_beats), m_beats16, 0);

        // Bypass mode from reset
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        pin("byp_hd", int'(bus16.out_hd), m_hd, 4);
        pin("byp_comp", int'(bus16.out_comp), m_comp, 0);
        pin("byp_hdc", int'(bus16.out_hd_comp), m_hdc, 0);
        pin("byp_sum", int'(bus16.out_hd_sum), m_sum, 4);

        // Backpressure: 5 stall cycles with a second word waiting
        do_reset();
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b0);
            pin("stall_data", int'(bus16.out_data), m_data, 8'h3C);
            pin("stall_comp", int'(bus16.out_comp), m_comp, 8'h0F);
        end
        step(1'b1, 8'h3D, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("bp_hd", int'(bus16.out_hd), m_hd, 1);
        pin("bp_comp", int'(bus16.out_comp), m_comp, 8'h70);
        pin("bp_beats", int'(bus16.stat_beats), m_beats16, 1);

        // Reset while a beat is held
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        pin_all_zero("midrst");
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        pin("post_rst_hd", int'(bus16.out_hd), m_hd, 1);
        pin("post_rst_comp", int'(bus16.out_comp), m_comp, 8'h7F);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 3) != 0),
                 8'($urandom),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
